// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing defaults and raster sizing helpers shared by the VGA timing blocks.
package vga_pkg;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   function automatic int h_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction
   function automatic int v_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction
   // bits needed to hold 0..n-1, never less than one
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r == 0) ? 1 : r;
   endfunction
endpackage

// File: rtl/vga_pix_ce_div.sv
// vga_pix_ce_div: divides clk by CLK_DIV into a one-clk-wide pixel clock-enable.
module vga_pix_ce_div
   import vga_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   output logic pix_ce
);
   localparam int CW = clog2(CLK_DIV);
   logic [CW-1:0] cnt, nxt;
   always_comb nxt = (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
   // pix_ce is registered so it stays low in reset even when CLK_DIV is 1
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt    <= '0;
         pix_ce <= 1'b0;
      end else begin
         cnt    <= nxt;
         pix_ce <= nxt == CW'(CLK_DIV - 1);
      end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster generator with registered, aligned sync/de/x/y and line/frame strobes.
// Define VGA_TEST_PATTERN_EN to drive eight vertical colour bars on rgb; otherwise rgb is tied low.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CLK_DIV  = 2,
   parameter int COLOR_W  = 1,
   parameter int XW       = clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
   parameter int YW       = clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 pix_ce,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic [XW-1:0]        x,
   output logic [YW-1:0]        y,
   output logic                 line_start,
   output logic                 frame_start,
   output logic [3*COLOR_W-1:0] rgb
);
   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HS_BEG  = H_ACTIVE + H_FP;
   localparam int HS_END  = HS_BEG + H_SYNC - 1;
   localparam int VS_BEG  = V_ACTIVE + V_FP;
   localparam int VS_END  = VS_BEG + V_SYNC - 1;
   logic [XW-1:0] h_cnt;
   logic [YW-1:0] v_cnt;
   logic h_end, v_end, hs_act, vs_act, de_n;
   vga_pix_ce_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk(clk),
      .rst(rst),
      .pix_ce(pix_ce)
   );
   always_comb begin
      h_end  = h_cnt == XW'(H_TOTAL - 1);
      v_end  = v_cnt == YW'(V_TOTAL - 1);
      hs_act = h_cnt >= XW'(HS_BEG) && h_cnt <= XW'(HS_END);
      vs_act = v_cnt >= YW'(VS_BEG) && v_cnt <= YW'(VS_END);
      de_n   = h_cnt < XW'(H_ACTIVE) && v_cnt < YW'(V_ACTIVE);
   end
   // outputs sample the counters on the pix_ce edge, so they trail the counters by one pixel
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         x           <= '0;
         y           <= '0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= pix_ce && h_cnt == '0;
         frame_start <= pix_ce && h_cnt == '0 && v_cnt == '0;
         if (pix_ce) begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end) v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            x     <= h_cnt;
            y     <= v_cnt;
            hsync <= hs_act ? HS_POL : ~HS_POL;
            vsync <= vs_act ? VS_POL : ~VS_POL;
            de    <= de_n;
         end
      end
`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;
   logic [2:0] bar;
   always_comb bar = 3'(h_cnt / XW'(BAR_W));
   always_ff @(posedge clk or posedge rst)
      if (rst) rgb <= '0;
      else if (pix_ce) rgb <= de_n ? {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}} : '0;
`else
   assign rgb = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a default 640x480 instance and a tiny active-high, undivided instance.
module tb_vga_timing_gen;
   logic clk = 1'b0, rst_a = 1'b1, rst_b = 1'b1;
   always #5 clk = ~clk;
   logic pa, hsa, vsa, dea, lsa, fsa;
   logic [9:0] xa, ya;
   logic [2:0] rgba;
   logic pb, hsb, vsb, deb, lsb, fsb;
   logic [3:0] xb, yb;
   logic [2:0] rgbb;
   int total = 0, bad = 0;
`ifdef VGA_TEST_PATTERN_EN
   localparam logic [2:0] EXP_400 = 3'b101, EXP_639 = 3'b111;
`else
   localparam logic [2:0] EXP_400 = 3'b000, EXP_639 = 3'b000;
`endif
   vga_timing_gen dut_a (
      .clk(clk), .rst(rst_a), .pix_ce(pa), .hsync(hsa), .vsync(vsa), .de(dea),
      .x(xa), .y(ya), .line_start(lsa), .frame_start(fsa), .rgb(rgba)
   );
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
      .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1)
   ) dut_b (
      .clk(clk), .rst(rst_b), .pix_ce(pb), .hsync(hsb), .vsync(vsb), .de(deb),
      .x(xb), .y(yb), .line_start(lsb), .frame_start(fsb), .rgb(rgbb)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   initial begin
      int n, c_pce, c_de, c_hs, c_vs, c_ls, c_fs, bad_hs, bad_de, bad_rgb0, wraps, x_max;
      logic [2:0] rgb400, rgb639, rgb640;
      logic [3:0] prev_x;
      repeat (4) @(negedge clk);
      chk("rst_hsync_a", hsa, 1);
      chk("rst_vsync_a", vsa, 1);
      chk("rst_de_a", dea, 0);
      chk("rst_xy_a", {xa, ya}, 0);
      chk("rst_strobes_a", {lsa, fsa}, 0);
      chk("rst_pce_a", pa, 0);
      chk("rst_rgb_a", rgba, 0);
      chk("rst_sync_b", {hsb, vsb}, 0);
      chk("rst_pce_b", pb, 0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      chk("first_pce_a", pa, 1);
      chk("early_fs_a", fsa, 0);
      chk("first_pce_b", pb, 1);
      @(negedge clk);
      chk("first_fs_a", fsa, 1);
      chk("first_ls_a", lsa, 1);
      chk("first_xy_a", {xa, ya}, 0);
      chk("second_pce_a", pa, 0);
      chk("first_fs_b", fsb, 1);
      c_pce = 0; c_de = 0; c_hs = 0; c_vs = 0; c_ls = 0; c_fs = 0;
      bad_hs = 0; bad_de = 0; bad_rgb0 = 0;
      rgb400 = 'x; rgb639 = 'x; rgb640 = 'x;
      for (int i = 0; i < 1600; i++) begin
         if (i > 0) @(negedge clk);
         c_pce += int'(pa);
         c_de  += int'(dea);
         c_hs  += int'(!hsa);
         c_vs  += int'(!vsa);
         c_ls  += int'(lsa);
         c_fs  += int'(fsa);
         if (hsa !== !(xa >= 10'd656 && xa <= 10'd751)) bad_hs++;
         if (dea !== (xa < 10'd640)) bad_de++;
         if (xa < 10'd80 && rgba !== 3'b000) bad_rgb0++;
         if (xa == 10'd400) rgb400 = rgba;
         if (xa == 10'd639) rgb639 = rgba;
         if (xa == 10'd640) rgb640 = rgba;
      end
      chk("line_pce_count", c_pce, 800);
      chk("line_de_clks", c_de, 1280);
      chk("line_hs_clks", c_hs, 192);
      chk("line_hs_shape", bad_hs, 0);
      chk("line_de_shape", bad_de, 0);
      chk("line_vs_low", c_vs, 0);
      chk("line_ls_clks", c_ls, 1);
      chk("line_fs_clks", c_fs, 1);
      chk("rgb_x0_79", bad_rgb0, 0);
      chk("rgb_x400", rgb400, EXP_400);
      chk("rgb_x639", rgb639, EXP_639);
      chk("rgb_x640", rgb640, 0);
      @(negedge clk);
      chk("line2_ls", lsa, 1);
      chk("line2_fs", fsa, 0);
      chk("line2_xy", {xa, ya}, {10'd0, 10'd1});
      n = 0;
      while (xa !== 10'd300 && n < 1000) begin @(negedge clk); n++; end
      chk("wait_x300_a", n < 1000, 1);
      chk("pre_rst_de_a", dea, 1);
      rst_a = 1'b1;
      #1;
      chk("midrst_xy_a", {xa, ya}, 0);
      chk("midrst_de_a", dea, 0);
      chk("midrst_hs_a", hsa, 1);
      chk("midrst_pce_a", pa, 0);
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);
      chk("post_rst_pce_a", pa, 1);
      @(negedge clk);
      chk("post_rst_fs_a", fsa, 1);
      chk("post_rst_xy_a", {xa, ya}, 0);
      n = 0;
      while (fsb !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("wait_fs_b", n < 200, 1);
      c_pce = 0; c_de = 0; c_hs = 0; c_vs = 0; c_fs = 0; bad_hs = 0;
      wraps = 0; x_max = 0; prev_x = xb;
      for (int i = 0; i < 140; i++) begin
         if (i > 0) @(negedge clk);
         c_pce += int'(pb);
         c_de  += int'(deb);
         c_hs  += int'(hsb);
         c_vs  += int'(vsb);
         c_fs  += int'(fsb);
         if (vsb !== (yb >= 4'd6 && yb <= 4'd7)) bad_hs++;
         if (i > 0 && prev_x == 4'd13 && xb == 4'd0) wraps++;
         if (int'(xb) > x_max) x_max = int'(xb);
         prev_x = xb;
      end
      chk("frame_pce_b", c_pce, 140);
      chk("frame_de_b", c_de, 32);
      chk("frame_hs_b", c_hs, 20);
      chk("frame_vs_b", c_vs, 28);
      chk("frame_vs_shape_b", bad_hs, 0);
      chk("frame_fs_b", c_fs, 1);
      chk("frame_wraps_b", wraps, 9);
      chk("frame_xmax_b", x_max, 13);
      @(negedge clk);
      chk("frame2_fs_b", fsb, 1);
      chk("frame2_ls_b", lsb, 1);
      n = 0;
      while (!(xb === 4'd5 && yb === 4'd2) && n < 200) begin @(negedge clk); n++; end
      chk("wait_x5y2_b", n < 200, 1);
      chk("pre_rst_de_b", deb, 1);
      rst_b = 1'b1;
      #1;
      chk("midrst_xy_b", {xb, yb}, 0);
      chk("midrst_de_b", deb, 0);
      chk("midrst_sync_b", {hsb, vsb}, 0);
      repeat (2) @(negedge clk);
      rst_b = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_fs_b", fsb, 1);
      chk("post_rst_xy_b", {xb, yb}, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
